sal_arbiter_wrr: RTL and testbench
==================================

Name: sal_arbiter_wrr

Overview:
Parametrised N-to-1 weighted round-robin arbiter with a registered one-entry output stage, replacing fixed-radix RR trees in request-merge paths such as DRAM command queues and bank schedulers. Each requester receives up to WEIGHT grants in a row before priority rotates. Output uses the same req/gnt handshake as upstream arbiters, so instances can be cascaded.

Parameters:
REQ_CNT, 8, number of requesters (2..64, any value, not only a power of 2)
REQ_CNT_LG2, $clog2(REQ_CNT), width of the source index
DATA_WIDTH, 12, payload width per requester
WEIGHT_WIDTH, 4, width of each per-requester weight / credit counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_arr_i  input  REQ_CNT  per-requester request
data_arr_i  input  DATA_WIDTH x REQ_CNT  unpacked payload array [0:REQ_CNT-1]
weight_arr_i  input  WEIGHT_WIDTH x REQ_CNT  per-requester weight, quasi-static
gnt_arr_o  output  REQ_CNT  one-hot grant; payload captured this cycle
req_o  output  1  output entry valid
data_o  output  DATA_WIDTH  registered payload of the granted requester
src_o  output  REQ_CNT_LG2  index of the requester that produced data_o
gnt_i  input  1  downstream accepts the output entry (req_o && gnt_i = pop)

Behaviour:
- Reset (async assert, sync deassert by the clk domain): req_o=0, data_o=0, src_o=0, owner pointer=0, credit=0. gnt_arr_o=0 because no request is being evaluated.
- load_en = !req_o || gnt_i. gnt_arr_o is combinational and non-zero only when load_en is high and |req_arr_i is high. It is always one-hot.
- Latency: a grant in cycle T makes req_o=1, data_o=data_arr_i[winner] and src_o=winner in cycle T+1.
- Throughput: one entry per cycle when gnt_i is held high. When req_o && !gnt_i, data_o and src_o hold and gnt_arr_o=0.
- Arbitration, evaluated only when load_en is high:
  - HOLD case: owner requests and credit>0. Winner = owner; credit decrements.
  - ROTATE case: otherwise, winner = first requester found scanning from (owner+1) mod REQ_CNT upward with wrap-around. The owner is checked last. owner<=winner; credit<=eff_weight(winner)-1.
  - eff_weight(w) = 1 when weight_arr_i[w]==0, otherwise weight_arr_i[w]. Weight 0 never blocks a requester.
  - No request: no grant. Owner and credit hold. req_o clears on pop.
- Owner drops its request while credit>0: the arbiter rotates on the next evaluation and the leftover credit is discarded.
- Pop and a new grant in the same cycle: the output register reloads, so req_o stays 1.
- Single active requester with weight W: it is granted every cycle, and the credit reloads each time it reaches 0.
- Weight changes take effect at the next ROTATE into that requester. Credit in progress is not modified.
- REQ_CNT not a power of 2: the wrap is at REQ_CNT-1 -> 0. Pointer values >= REQ_CNT are unreachable.
- Reset mid-burst: the in-flight output entry is dropped. Requesters must not treat a grant as consumed past reset.

Optional Feature:
Macro SAL_ARBITER_WRR_LOCK_EN.
- Defined: adds input lock_i (1 bit). While lock_i=1 and the owner requests, HOLD is forced regardless of credit, and credit does not decrement. Intended for multi-beat atomic transfers. If lock_i=1 but the owner is idle, normal rotation applies.
- Undefined: no lock_i port; behaviour exactly as above.

Decomposition:
- Package sal_arb_pkg:
  - function f_eff_weight
  - localparam SAL_ARB_MAX_REQ=64
  - typedef arb_state_t {ARB_IDLE, ARB_HOLD}, encoding whether the credit/owner is live; ARB_IDLE after reset and after a drained burst.
- One sub-module: sal_arb_rr_pick, a combinational rotated priority picker. Inputs: req vector and start index. Outputs: one-hot and index. It is reusable by other schedulers.

Test Plan:
1. REQ_CNT=4, all weights=1, all requesting, gnt_i=1 -> src_o sequence 1,2,3,0,1,... (owner reset 0 so first pick is 1); one grant per cycle.
2. weights {3,1,2,0}, all requesting, gnt_i=1 -> src_o sequence 1,2,2,3,0,0,0,1,2,2,3,... (weight 0 acts as 1).
3. req_arr_i=4'b0101, gnt_i low 5 cycles after first grant -> req_o=1, data_o and src_o stable, gnt_arr_o=0 for 5 cycles; on gnt_i=1 the next grant occurs the same cycle.
4. Owner 0 with weight 3 drops its request after 1 grant while 2 requests -> next winner is 2; when 0 re-requests it gets a fresh credit of 3.
5. REQ_CNT=5, only requester 4 then 0 active -> wrap 4->0 correct; src_o width is 3, no X.
6. rst_n asserted mid-burst with req_o=1 -> req_o=0, data_o=0 asynchronously; after release the first grant goes to requester 1 if all request.

Source files
------------

// File: rtl/sal_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter family.
// Holds the credit-state encoding and the effective-weight helper. A zero
// weight is treated as one so that it can never starve a requester.
package sal_arb_pkg;

  localparam int SAL_ARB_MAX_REQ = 64;

  // ARB_IDLE: no live credit, so the next evaluation rotates.
  // ARB_HOLD: the owner still has credit left in its burst.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  // A zero weight is granted as if it were one.
  function automatic logic [31:0] f_eff_weight(input logic [31:0] weight);
    return (weight == 32'd0) ? 32'd1 : weight;
  endfunction

endpackage

// File: rtl/sal_arb_rr_pick.sv
// Combinational rotated priority picker. It scans req upward from start
// and wraps at REQ_CNT-1 -> 0, so any requester count is supported.
// It returns the first hit as a one-hot vector and as an index.
// start must be below REQ_CNT.
module sal_arb_rr_pick #(
  parameter int REQ_CNT = 8,
  parameter int IDX_W   = $clog2(REQ_CNT)
) (
  input  logic [REQ_CNT-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [REQ_CNT-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // First requester at or after start, with wrap-around.
  always_comb begin
    int pos;
    pos    = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = 0; i < REQ_CNT; i++) begin
      pos = int'(start) + i;
      if (pos >= REQ_CNT) pos = pos - REQ_CNT;
      if (!valid && req[pos]) begin
        valid       = 1'b1;
        idx         = IDX_W'(pos);
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_arbiter_wrr.sv
// N-to-1 weighted round-robin arbiter with a one-entry registered output.
// The owner keeps winning while it requests and has credit left. After
// that, the priority rotates to the next requester above the owner.
// Handshake: upstream and downstream both use req/gnt. A requester's
// payload is captured in the cycle that its gnt_arr_o bit is high. The
// output entry is consumed when req_o && gnt_i. A new grant is made only
// when the output register is empty or is being popped in the same cycle.
// Optional macro SAL_ARBITER_WRR_LOCK_EN adds lock_i. While lock_i is high,
// a requesting owner is held without spending credit.
module sal_arbiter_wrr
  import sal_arb_pkg::*;
#(
  parameter int REQ_CNT      = 8,
  parameter int REQ_CNT_LG2  = $clog2(REQ_CNT),
  parameter int DATA_WIDTH   = 12,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REQ_CNT-1:0]      req_arr_i,
  input  logic [DATA_WIDTH-1:0]   data_arr_i   [0:REQ_CNT-1],
  input  logic [WEIGHT_WIDTH-1:0] weight_arr_i [0:REQ_CNT-1],
`ifdef SAL_ARBITER_WRR_LOCK_EN
  input  logic                    lock_i,
`endif
  output logic [REQ_CNT-1:0]      gnt_arr_o,
  output logic                    req_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [REQ_CNT_LG2-1:0]  src_o,
  input  logic                    gnt_i
);

  arb_state_t               arb_state;
  logic [REQ_CNT_LG2-1:0]   owner;
  logic [WEIGHT_WIDTH-1:0]  credit;

  logic [REQ_CNT_LG2-1:0]   pick_start;
  logic [REQ_CNT_LG2-1:0]   pick_idx;
  logic [REQ_CNT-1:0]       pick_onehot;
  logic                     pick_valid;
  logic [REQ_CNT_LG2-1:0]   win_idx;
  logic [REQ_CNT-1:0]       owner_onehot;
  logic [WEIGHT_WIDTH-1:0]  new_credit;
  logic                     load_en;
  logic                     owner_req;
  logic                     lock_hold;
  logic                     hold_case;
  logic                     grant_valid;

  assign load_en   = !req_o || gnt_i;
  assign owner_req = req_arr_i[owner];

  // The scan starts just above the owner, so the owner is checked last.
  assign pick_start = (owner == REQ_CNT_LG2'(REQ_CNT - 1)) ? '0
                                                           : owner + REQ_CNT_LG2'(1);

  sal_arb_rr_pick #(
    .REQ_CNT (REQ_CNT),
    .IDX_W   (REQ_CNT_LG2)
  ) u_pick (
    .req    (req_arr_i),
    .start  (pick_start),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

`ifdef SAL_ARBITER_WRR_LOCK_EN
  assign lock_hold = lock_i && owner_req;
`else
  assign lock_hold = 1'b0;
`endif

  assign hold_case   = (owner_req && (arb_state == ARB_HOLD)) || lock_hold;
  // Grants are suppressed during reset so that no payload is consumed then.
  assign grant_valid = rst_n && load_en && pick_valid;
  assign win_idx     = hold_case ? owner : pick_idx;
  assign new_credit  = WEIGHT_WIDTH'(f_eff_weight(32'(weight_arr_i[pick_idx])) - 32'd1);

  // One-hot decode of the current owner, used for HOLD grants.
  always_comb begin
    owner_onehot        = '0;
    owner_onehot[owner] = 1'b1;
  end

  assign gnt_arr_o = grant_valid ? (hold_case ? owner_onehot : pick_onehot) : '0;

  // Owner/credit state and the registered output entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_state <= ARB_IDLE;
      owner     <= '0;
      credit    <= '0;
      req_o     <= 1'b0;
      data_o    <= '0;
      src_o     <= '0;
    end else if (grant_valid) begin
      req_o  <= 1'b1;
      data_o <= data_arr_i[win_idx];
      src_o  <= win_idx;
      if (hold_case) begin
        if (!lock_hold) begin
          credit    <= credit - WEIGHT_WIDTH'(1);
          arb_state <= (credit == WEIGHT_WIDTH'(1)) ? ARB_IDLE : ARB_HOLD;
        end
      end else begin
        owner     <= pick_idx;
        credit    <= new_credit;
        arb_state <= (new_credit != '0) ? ARB_HOLD : ARB_IDLE;
      end
    end else if (gnt_i) begin
      req_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sal_arbiter_wrr.sv
// Bench for sal_arbiter_wrr with REQ_CNT=5, which is not a power of two.
// A behavioural arbiter model predicts every grant vector. It pushes each
// expected {src, data} entry into a queue, and the entry is compared when
// it is popped downstream. Table rows and short directed sequences add
// hand-derived expectations on top of the model.
module tb_sal_arbiter_wrr;

  localparam int N  = 5;
  localparam int LG = 3;
  localparam int DW = 12;
  localparam int WW = 4;
  localparam int W  = LG + DW;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_arr_i;
  logic [DW-1:0] data_arr_i   [0:N-1];
  logic [WW-1:0] weight_arr_i [0:N-1];
  logic [N-1:0]  gnt_arr_o;
  logic          req_o;
  logic [DW-1:0] data_o;
  logic [LG-1:0] src_o;
  logic          gnt_i;

  sal_arbiter_wrr #(
    .REQ_CNT      (N),
    .REQ_CNT_LG2  (LG),
    .DATA_WIDTH   (DW),
    .WEIGHT_WIDTH (WW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_arr_i    (req_arr_i),
    .data_arr_i   (data_arr_i),
    .weight_arr_i (weight_arr_i),
    .gnt_arr_o    (gnt_arr_o),
    .req_o        (req_o),
    .data_o       (data_o),
    .src_o        (src_o),
    .gnt_i        (gnt_i)
  );

  // Clock and counters
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state and scoreboard
  int         m_owner;
  int         m_credit;
  logic       m_valid;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic set_weights(input logic [19:0] w);
    for (int i = 0; i < N; i++) weight_arr_i[i] = w[i*4 +: 4];
  endtask

  // Reset is asserted away from the clock edge. Its effect is checked before
  // the next rising edge, which shows that it is asynchronous.
  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_arr_i = '0;
    gnt_i     = 1'b0;
    #1;
    chk("rst_req_o", 32'(req_o), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    chk("rst_src_o", 32'(src_o), 32'd0);
    chk("rst_gnt_arr", 32'(gnt_arr_o), 32'd0);
    m_owner  = 0;
    m_credit = 0;
    m_valid  = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Each cycle drives the inputs, checks the registered entry (popped when
  // it is consumed), then advances the model and checks the grant vector.
  task automatic cycle(input logic [N-1:0] req, input logic g);
    logic [N-1:0] eg;
    logic [LG-1:0] win;
    logic [W-1:0] ent;
    logic found;
    int idx;
    @(negedge clk);
    req_arr_i = req;
    gnt_i     = g;
    for (int i = 0; i < N; i++) data_arr_i[i] = DW'($urandom);
    #1;
    chk("req_o", 32'(req_o), 32'(m_valid));
    if (m_valid && g) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty actual=pop required=no_entry");
      end else begin
        ent = exp_q.pop_front();
        chk("out_entry", 32'({src_o, data_o}), 32'(ent));
      end
    end
    eg = '0;
    win = '0;
    if ((!m_valid || g) && (req != '0)) begin
      if (req[m_owner] && m_credit != 0) begin
        win = LG'(m_owner);
        m_credit--;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_owner + k) % N;
          if (!found && req[idx]) begin
            found = 1'b1;
            win = LG'(idx);
          end
        end
        m_owner  = int'(win);
        m_credit = (weight_arr_i[win] == 0) ? 0 : int'(weight_arr_i[win]) - 1;
      end
      eg[win] = 1'b1;
      exp_q.push_back({win, data_arr_i[win]});
      m_valid = 1'b1;
    end else if (g) begin
      m_valid = 1'b0;
    end
    chk("gnt_arr_o", 32'(gnt_arr_o), 32'(eg));
  endtask

  // Table vectors. Each row shows the registered output seen during that row,
  // which is the result of the previous row's grant.
  typedef struct packed {
    logic          rst;
    logic [19:0]   w;
    logic [N-1:0]  req;
    logic          gnt;
    logic          exp_v;
    logic [LG-1:0] exp_src;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [19:0] w, input logic [N-1:0] q,
                              input logic g, input logic v, input logic [LG-1:0] s);
    vec_t t;
    t.rst = r; t.w = w; t.req = q; t.gnt = g; t.exp_v = v; t.exp_src = s;
    return t;
  endfunction

  logic [N-1:0] t4_exp [0:5];
  logic [N-1:0] t4_req [0:5];

  initial begin
    rst_n     = 1'b0;
    req_arr_i = '0;
    gnt_i     = 1'b0;
    for (int i = 0; i < N; i++) data_arr_i[i] = '0;
    set_weights(20'h11111);
    m_owner = 0; m_credit = 0; m_valid = 1'b0;

    // All weights 1: plain rotation 1,2,3,4,0,1 starting after owner 0.
    vecs.push_back(mk(1'b1, 20'h11111, 5'h1f, 1'b1, 1'b0, 3'd0));
    vecs.push_back(mk(1'b0, 20'h11111, 5'h1f, 1'b1, 1'b1, 3'd1));
    vecs.push_back(mk(1'b0, 20'h11111, 5'h1f, 1'b1, 1'b1, 3'd2));
    vecs.push_back(mk(1'b0, 20'h11111, 5'h1f, 1'b1, 1'b1, 3'd3));
    vecs.push_back(mk(1'b0, 20'h11111, 5'h1f, 1'b1, 1'b1, 3'd4));
    vecs.push_back(mk(1'b0, 20'h11111, 5'h1f, 1'b1, 1'b1, 3'd0));
    vecs.push_back(mk(1'b0, 20'h11111, 5'h1f, 1'b1, 1'b1, 3'd1));
    // Weights {w4..w0} = {1,0,2,1,3}: 1,2,2,3,4,0,0,0,1,2,2 (weight 0 acts as 1).
    vecs.push_back(mk(1'b1, 20'h10213, 5'h1f, 1'b1, 1'b0, 3'd0));
    vecs.push_back(mk(1'b0, 20'h10213, 5'h1f, 1'b1, 1'b1, 3'd1));
    vecs.push_back(mk(1'b0, 20'h10213, 5'h1f, 1'b1, 1'b1, 3'd2));
    vecs.push_back(mk(1'b0, 20'h10213, 5'h1f, 1'b1, 1'b1, 3'd2));
    vecs.push_back(mk(1'b0, 20'h10213, 5'h1f, 1'b1, 1'b1, 3'd3));
    vecs.push_back(mk(1'b0, 20'h10213, 5'h1f, 1'b1, 1'b1, 3'd4));
    vecs.push_back(mk(1'b0, 20'h10213, 5'h1f, 1'b1, 1'b1, 3'd0));
    vecs.push_back(mk(1'b0, 20'h10213, 5'h1f, 1'b1, 1'b1, 3'd0));
    vecs.push_back(mk(1'b0, 20'h10213, 5'h1f, 1'b1, 1'b1, 3'd0));
    vecs.push_back(mk(1'b0, 20'h10213, 5'h1f, 1'b1, 1'b1, 3'd1));
    vecs.push_back(mk(1'b0, 20'h10213, 5'h1f, 1'b1, 1'b1, 3'd2));
    vecs.push_back(mk(1'b0, 20'h10213, 5'h1f, 1'b1, 1'b1, 3'd2));

    foreach (vecs[i]) begin
      set_weights(vecs[i].w);
      if (vecs[i].rst) do_reset();
      cycle(vecs[i].req, vecs[i].gnt);
      chk("tbl_req_o", 32'(req_o), 32'(vecs[i].exp_v));
      chk("tbl_src_o", 32'(src_o), 32'(vecs[i].exp_src));
    end

    // Backpressure: the entry holds and no grants are made while gnt_i is low.
    set_weights(20'h11111);
    do_reset();
    cycle(5'b00101, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(5'b00101, 1'b0);
      chk("stall_src", 32'(src_o), 32'd2);
      chk("stall_gnt", 32'(gnt_arr_o), 32'd0);
      if (exp_q.size() == 1) chk("stall_entry", 32'({src_o, data_o}), 32'(exp_q[0]));
      else chk("stall_qdepth", 32'(exp_q.size()), 32'd1);
    end
    cycle(5'b00101, 1'b1);
    chk("release_gnt", 32'(gnt_arr_o), 32'b00001);
    cycle(5'b00000, 1'b1);
    chk("release_req_o", 32'(req_o), 32'd1);
    chk("release_src", 32'(src_o), 32'd0);

    // Owner 0 (weight 3) drops out after one grant; 2 wins; 0 returns with a full credit.
    set_weights(20'h11113);
    do_reset();
    t4_req[0] = 5'b00001; t4_exp[0] = 5'b00001;
    t4_req[1] = 5'b00100; t4_exp[1] = 5'b00100;
    t4_req[2] = 5'b00101; t4_exp[2] = 5'b00001;
    t4_req[3] = 5'b00101; t4_exp[3] = 5'b00001;
    t4_req[4] = 5'b00101; t4_exp[4] = 5'b00001;
    t4_req[5] = 5'b00101; t4_exp[5] = 5'b00100;
    for (int i = 0; i < 6; i++) begin
      cycle(t4_req[i], 1'b1);
      chk("drop_gnt", 32'(gnt_arr_o), 32'(t4_exp[i]));
    end

    // Wrap 4 -> 0 with five requesters.
    set_weights(20'h11111);
    do_reset();
    cycle(5'b10000, 1'b1);
    chk("wrap_gnt4", 32'(gnt_arr_o), 32'b10000);
    cycle(5'b00001, 1'b1);
    chk("wrap_gnt0", 32'(gnt_arr_o), 32'b00001);
    chk("wrap_src4", 32'(src_o), 32'd4);
    cycle(5'b00000, 1'b1);
    chk("wrap_src0", 32'(src_o), 32'd0);
    chk("wrap_src_known", 32'($isunknown(src_o)), 32'd0);

    // Reset mid-burst drops the in-flight entry; the first grant afterwards goes to 1.
    cycle(5'b11111, 1'b1);
    cycle(5'b11111, 1'b1);
    cycle(5'b11111, 1'b1);
    chk("burst_req_o", 32'(req_o), 32'd1);
    do_reset();
    cycle(5'b11111, 1'b1);
    chk("post_rst_gnt", 32'(gnt_arr_o), 32'b00010);
    cycle(5'b11111, 1'b1);
    chk("post_rst_src", 32'(src_o), 32'd1);

    // Random traffic with random backpressure and fixed random weights.
    for (int i = 0; i < N; i++) weight_arr_i[i] = WW'($urandom_range(0, 3));
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0));
    end
    cycle(5'b00000, 1'b1);
    cycle(5'b00000, 1'b1);
    chk("final_qdepth", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
